// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   - controller state encoding (ST_* constants and the state_t enum built on them)
//   - Booth recoding operation (booth_op_t) and the decode helper that maps
//     the {Q[0], q-1} bit pair onto an operation
package booth_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding: 10 starts a run of ones (subtract),
    // 01 ends a run of ones (add), 00/11 are inside a run (no-op).
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        op = BOOTH_NOP;
        case ({q0, qm1})
            2'b10:   op = BOOTH_SUB;
            2'b01:   op = BOOTH_ADD;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational W-bit adder/subtractor, modulo 2^W.
// Ports:
//   a, b  in  W  operands
//   sub   in  1  1 = a - b, 0 = a + b
//   z     out W  result
module booth_addsub #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] z
);

    assign z = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with integrated controller.
// Multiplies two WIDTH-bit operands (signed or unsigned per request) in
// WIDTH+1 Booth steps and returns a 2*WIDTH-bit product.
// Handshake: start is sampled only in IDLE together with signed_mode and both
// operands; busy is high in RUN and DONE; done is a one-cycle pulse
// registered on the DONE->IDLE edge, so a start raised during that pulse
// is accepted at the next edge. product holds until the next accepted start.
// Ports:
//   clk           in  1        rising-edge clock
//   rst           in  1        synchronous active-high reset
//   start         in  1        request
//   signed_mode   in  1        1 = two's-complement operands
//   multiplicand  in  WIDTH    M operand
//   multiplier    in  WIDTH    Q operand
//   busy          out 1        request in progress
//   done          out 1        product valid pulse
//   product       out 2*WIDTH  result
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // One guard bit keeps A +/- M from overflowing, even for the most
    // negative operand squared, and lets unsigned operands look positive.
    localparam int XW = WIDTH + 1;

    state_t          state;
    state_t          state_nxt;
    logic [XW-1:0]   a_reg;
    logic [XW-1:0]   m_reg;
    logic [XW-1:0]   q_reg;
    logic            qm1;
    logic [CNT_W-1:0] cnt;

    booth_op_t       op;
    logic [XW-1:0]   sum;
    logic [XW-1:0]   a_step;

    assign op     = booth_decode(q_reg[0], qm1);
    assign a_step = (op == BOOTH_NOP) ? a_reg : sum;

    booth_addsub #(.W(XW)) u_addsub (
        .a   (a_reg),
        .b   (m_reg),
        .sub (op == BOOTH_SUB),
        .z   (sum)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // cnt==1 here means this edge performs the final step.
                if (cnt == CNT_W'(1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            qm1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg   <= {signed_mode & multiplicand[WIDTH-1], multiplicand};
                        q_reg   <= {signed_mode & multiplier[WIDTH-1], multiplier};
                        a_reg   <= '0;
                        qm1     <= 1'b0;
                        cnt     <= CNT_W'(WIDTH + 1);
                        product <= '0;
                    end
                end
                S_RUN: begin
                    // Arithmetic shift right of {A, Q, qm1} after the add/sub.
                    a_reg <= {a_step[XW-1], a_step[XW-1:1]};
                    q_reg <= {a_step[0], q_reg[XW-1:1]};
                    qm1   <= q_reg[0];
                    cnt   <= cnt - CNT_W'(1);
                end
                S_DONE: begin
                    // Low 2*WIDTH bits of {A, Q}.
                    product <= {a_reg[WIDTH-2:0], q_reg};
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=16 directed vectors with latency checks,
// WIDTH=4 exhaustive and WIDTH=32 corner/random runs against a product model.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic rst = 1'b1;

    // WIDTH=16 instance
    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    // WIDTH=4 instance
    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;

    // WIDTH=32 instance
    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] prod32;

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .multiplicand(a16), .multiplier(b16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .multiplicand(a4), .multiplier(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    booth_mult_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .multiplicand(a32), .multiplier(b32),
        .busy(busy32), .done(done32), .product(prod32)
    );

    logic [31:0] exp16_q[$];
    int          due16_q[$];
    logic [7:0]  exp4_q[$];
    logic [63:0] exp32_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done16) begin
            if (exp16_q.size() == 0) begin
                flag("w16 unexpected done");
            end else begin
                check("w16 product", prod16, exp16_q.pop_front());
                check("w16 done cycle", cyc, due16_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (exp4_q.size() == 0) flag("w4 unexpected done");
            else check("w4 product", prod4, exp4_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (done32) begin
            if (exp32_q.size() == 0) flag("w32 unexpected done");
            else check("w32 product", prod32, exp32_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_idle16();
        int n = 0;
        while (busy16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy16) flag("w16 busy timeout");
    endtask

    // Present a request at a negedge; it is accepted at the following edge.
    task automatic issue16(input logic [15:0] m, input logic [15:0] q, input logic sm,
                           input logic [31:0] exp, input bit push);
        wait_idle16();
        start16 = 1'b1; a16 = m; b16 = q; sm16 = sm;
        if (push) begin
            exp16_q.push_back(exp);
            due16_q.push_back(cyc + 19);
        end
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] m, input logic [3:0] q, input logic sm);
        logic signed [7:0] sp;
        logic [7:0]        up;
        int n = 0;
        while (busy4 && n < 50) begin @(negedge clk); n++; end
        if (busy4) flag("w4 busy timeout");
        sp = $signed({{4{m[3]}}, m}) * $signed({{4{q[3]}}, q});
        up = {4'b0, m} * {4'b0, q};
        exp4_q.push_back(sm ? sp : up);
        start4 = 1'b1; a4 = m; b4 = q; sm4 = sm;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issue32(input logic [31:0] m, input logic [31:0] q, input logic sm);
        longint      sp;
        logic [63:0] up;
        int n = 0;
        while (busy32 && n < 100) begin @(negedge clk); n++; end
        if (busy32) flag("w32 busy timeout");
        sp = longint'($signed(m)) * longint'($signed(q));
        up = {32'b0, m} * {32'b0, q};
        exp32_q.push_back(sm ? 64'(sp) : up);
        start32 = 1'b1; a32 = m; b32 = q; sm32 = sm;
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp16_q.size() + exp4_q.size() + exp32_q.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if ((exp16_q.size() + exp4_q.size() + exp32_q.size()) != 0) begin
            flag({name, " drain timeout"});
            exp16_q.delete(); due16_q.delete(); exp4_q.delete(); exp32_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int busy_cnt;

        repeat (3) @(negedge clk);
        check("reset busy", busy16, 0);
        check("reset done", done16, 0);
        check("reset product", prod16, 0);
        check("reset busy w4", busy4, 0);
        rst = 1'b0;
        @(negedge clk);

        // directed WIDTH=16 vectors
        issue16(16'h0003, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, 1'b1);
        issue16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 1'b1);
        issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b1);
        issue16(16'h8000, 16'h0002, 1'b0, 32'h0001_0000, 1'b1);
        issue16(16'h8000, 16'h0002, 1'b1, 32'hFFFF_0000, 1'b1);
        issue16(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, 1'b1);
        issue16(16'h1234, 16'h5678, 1'b0, 32'h0626_0060, 1'b1);
        issue16(16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, 1'b1);
        issue16(16'h0000, 16'h1234, 1'b1, 32'h0000_0000, 1'b1);
        drain("directed");
        @(negedge clk);
        check("product held after done", prod16, 32'h0000_0000);

        // start held high, operands changed during RUN
        wait_idle16();
        c = cyc;
        start16 = 1'b1; a16 = 16'h0003; b16 = 16'h0005; sm16 = 1'b0;
        exp16_q.push_back(32'h0000_000F);
        due16_q.push_back(c + 19);
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) begin a16 = 16'h0010; b16 = 16'h0010; end
            if (k <= 19 && busy16) busy_cnt++;
            if (k == 19) begin
                check("busy low in done cycle", busy16, 0);
                exp16_q.push_back(32'h0000_0100);
                due16_q.push_back(c + 20 + 18);
            end
            if (k == 20) begin
                check("re-accept after done", busy16, 1);
                start16 = 1'b0;
            end
        end
        check("busy cycles per request", busy_cnt, 18);
        drain("held start");

        // reset during RUN step 7
        wait_idle16();
        issue16(16'h1234, 16'h1111, 1'b0, 32'h0, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", busy16, 0);
        check("abort done", done16, 0);
        check("abort product", prod16, 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        issue16(16'h0007, 16'h0006, 1'b0, 32'h0000_002A, 1'b1);
        drain("after abort");

        // WIDTH=4 exhaustive, both modes
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    issue4(4'(i), 4'(j), s[0]);
        drain("w4");

        // WIDTH=32 corners and random
        issue32(32'h8000_0000, 32'h8000_0000, 1'b1);
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue32(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        issue32(32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        for (int r = 0; r < 250; r++)
            issue32($urandom, $urandom, 1'($urandom_range(0, 1)));
        drain("w32");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
